// File: rtl/dot_mac_pipe.sv
// ============================================================================
//  Module   : dot_mac_pipe
//  Purpose  : Pipelined unsigned sum-of-products engine with optional frame
//             accumulation. Define MAC_SAT_EN for saturating accumulation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_mac_pipe #(
    parameter int W     = 8,
    parameter int CH    = 3,
    parameter int ACC_W = 9
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    input  logic                                  mode,
    input  logic [CH*W-1:0]                       a_bus,
    input  logic [CH*W-1:0]                       b_bus,
    output logic                                  out_valid,
    output logic [2*W+$clog2(CH)+ACC_W-1:0]       out_data,
    output logic                                  out_ovf
);

    localparam int c_PW = 2*W + $clog2(CH) + ACC_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // S0: input capture
    logic              r_s0_valid;
    logic              r_s0_last;
    logic              r_s0_mode;
    logic [CH*W-1:0]   r_s0_a;
    logic [CH*W-1:0]   r_s0_b;

    // S1: products
    logic                      r_s1_valid;
    logic                      r_s1_last;
    logic                      r_s1_mode;
    logic [CH-1:0][2*W-1:0]    w_prod;
    logic [CH-1:0][2*W-1:0]    r_s1_prod;

    // S2: adder tree
    logic              r_s2_valid;
    logic              r_s2_last;
    logic              r_s2_mode;
    logic [c_PW-1:0]   w_sum;
    logic [c_PW-1:0]   r_s2_sum;

    // S3: frame accumulator and result
    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_PW-1:0]   r_acc;
    logic [c_PW-1:0]   w_acc_nxt;
    logic [c_PW-1:0]   w_acc_base;
    logic [c_PW-1:0]   w_total;
    logic [c_PW-1:0]   r_res;
    logic [c_PW-1:0]   w_res_nxt;
    logic              r_res_valid;
    logic              w_res_valid_nxt;

    // Operand registers only load on accepted beats so idle buses never move state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s0_valid <= 1'b0;
        end else begin
            r_s0_valid <= in_valid;
        end
        if (in_valid) begin
            r_s0_last <= in_last;
            r_s0_mode <= mode;
            r_s0_a    <= a_bus;
            r_s0_b    <= b_bus;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_prod
        assign w_prod[gi] = r_s0_a[gi*W +: W] * r_s0_b[gi*W +: W];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s0_valid;
        end
        if (r_s0_valid) begin
            r_s1_last <= r_s0_last;
            r_s1_mode <= r_s0_mode;
            r_s1_prod <= w_prod;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CH; i++) begin
            w_sum = w_sum + c_PW'(r_s1_prod[i]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
        end
        if (r_s1_valid) begin
            r_s2_last <= r_s1_last;
            r_s2_mode <= r_s1_mode;
            r_s2_sum  <= w_sum;
        end
    end

    assign w_acc_base = (r_state == ST_ACC) ? r_acc : '0;

`ifdef MAC_SAT_EN
    localparam logic [c_PW-1:0] c_MAX = '1;

    logic [c_PW:0] w_wide;
    logic          w_ovf_total;
    logic          r_ovf;
    logic          r_res_ovf;
    logic          r_out_ovf;

    assign w_wide      = {1'b0, w_acc_base} + {1'b0, r_s2_sum};
    // Once a frame has saturated it stays pinned at the maximum until it closes
    assign w_ovf_total = ((r_state == ST_ACC) & r_ovf) | w_wide[c_PW];
    assign w_total     = w_ovf_total ? c_MAX : w_wide[c_PW-1:0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ovf     <= 1'b0;
            r_res_ovf <= 1'b0;
            r_out_ovf <= 1'b0;
        end else begin
            if (r_s2_valid) begin
                r_ovf     <= r_s2_mode & ~r_s2_last & w_ovf_total;
                r_res_ovf <= r_s2_mode &  r_s2_last & w_ovf_total;
            end
            if (r_res_valid) begin
                r_out_ovf <= r_res_ovf;
            end
        end
    end

    assign out_ovf = r_out_ovf;
`else
    assign w_total = w_acc_base + r_s2_sum;
    assign out_ovf = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_res_nxt       = r_res;
        w_res_valid_nxt = 1'b0;
        if (r_s2_valid) begin
            if (!r_s2_mode) begin
                // A plain beat closes any open frame without emitting it
                w_state_nxt     = ST_IDLE;
                w_acc_nxt       = '0;
                w_res_nxt       = r_s2_sum;
                w_res_valid_nxt = 1'b1;
            end else if (r_s2_last) begin
                w_state_nxt     = ST_IDLE;
                w_acc_nxt       = '0;
                w_res_nxt       = w_total;
                w_res_valid_nxt = 1'b1;
            end else begin
                w_state_nxt     = ST_ACC;
                w_acc_nxt       = w_total;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_res       <= w_res_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    // Output register: result appears four edges after the beat is captured
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= r_res_valid;
            if (r_res_valid) begin
                out_data <= r_res;
            end
        end
    end

endmodule

`default_nettype wire
